// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS stopwatch.
package stopwatch_pkg;

  // Run-control state encoding; 2'd3 is unused and decodes back to idle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  // Largest legal value for a BCD ones digit and a minutes/seconds tens digit.
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control inputs and display outputs of the stopwatch, bundled for one port.
interface stopwatch_counter_if;

  logic       tickIn;
  logic       startPause;
  logic       clear;
  logic [3:0] minTens;
  logic [3:0] minOnes;
  logic [3:0] secTens;
  logic [3:0] secOnes;
  logic       running;
  logic       rollover;

  // Driver side: the timebase, the button and the clear level.
  modport master (
    output tickIn, startPause, clear,
    input  minTens, minOnes, secTens, secOnes, running, rollover
  );

  // Stopwatch side.
  modport slave (
    input  tickIn, startPause, clear,
    output minTens, minOnes, secTens, secOnes, running, rollover
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MAX, wrapping to 0 with a carry out.
module bcd_digit_counter #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;

  // Digit register: reset and clear zero it; an increment at or above MAX
  // reloads 0, which also scrubs any out-of-range value.
  always_ff @(posedge clkIn) begin
    if (!reset) begin
      digit_q <= 4'd0;
    end else if (clr) begin
      digit_q <= 4'd0;
    end else if (inc) begin
      digit_q <= (digit_q >= MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch driven by a one-cycle tick enable from the divider.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int PRESC_W  = 1
) (
  input  logic                      clkIn,
  input  logic                      reset,
  stopwatch_counter_if.slave        bus
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 start_pause_q;
  logic                 running_q;
  logic                 rollover_q;

  logic                 start_edge;
  logic                 run_tick;
  logic                 sec_inc;
  logic [4:0]           inc_w;
  logic [3:0]           digit_w [0:3];

  assign start_edge = bus.startPause & ~start_pause_q;

  // Ticks only count while the current state is RUN, so a tick arriving with
  // the start edge is dropped and one arriving with the pause edge is kept.
  assign run_tick = (state_q == ST_RUN) & bus.tickIn & ~bus.clear;
  assign sec_inc  = run_tick & (presc_q == PRESC_LAST);

  // Next-state and prescaler logic; clear dominates the button.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      if (start_edge) begin
        case (state_q)
          ST_IDLE:   state_d = ST_RUN;
          ST_RUN:    state_d = ST_PAUSED;
          ST_PAUSED: state_d = ST_RUN;
          default:   state_d = ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE && state_q != ST_RUN && state_q != ST_PAUSED) begin
        state_d = ST_IDLE;
      end
      if (run_tick) begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
      end
    end
  end

  // State, prescaler, button history and registered status outputs.
  always_ff @(posedge clkIn) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      start_pause_q <= bus.startPause;
      running_q     <= 1'b0;
      rollover_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      start_pause_q <= bus.startPause;
      running_q     <= (state_d == ST_RUN);
      rollover_q    <= inc_w[4];
    end
  end

  // Carry chain: digit 0 is secOnes, 3 is minTens; even positions are ones.
  assign inc_w[0] = sec_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      bcd_digit_counter #(
        .MAX ((gi % 2 == 0) ? ONES_MAX : TENS_MAX)
      ) u_digit (
        .clkIn (clkIn),
        .reset (reset),
        .clr   (bus.clear),
        .inc   (inc_w[gi]),
        .digit (digit_w[gi]),
        .carry (inc_w[gi+1])
      );
    end
  endgenerate

  assign bus.secOnes  = digit_w[0];
  assign bus.secTens  = digit_w[1];
  assign bus.minOnes  = digit_w[2];
  assign bus.minTens  = digit_w[3];
  assign bus.running  = running_q;
  assign bus.rollover = rollover_q;

endmodule
